// File: rtl/st7735_pixel_source.sv
// RGB565 test-pattern source for the ST7735 driver: raster-order pixels over valid/ready
// with frame/line markers. Define PIXSRC_BORDER_EN to force a FG-coloured one-pixel border.
module st7735_pixel_source #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 80,
  parameter int CHECKER_LOG2 = 3,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                      SYSTEM_CLK,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic [1:0]                MODE,
  input  logic [15:0]               FG_COLOR,
  input  logic [15:0]               BG_COLOR,
  output logic [15:0]               PIXEL_DATA,
  output logic                      PIXEL_VALID,
  input  logic                      PIXEL_READY,
  output logic                      FRAME_START,
  output logic                      LINE_END,
  output logic                      FRAME_END,
  output logic [$clog2(WIDTH):0]    PIXEL_X,
  output logic [$clog2(HEIGHT):0]   PIXEL_Y,
  output logic [7:0]                FRAME_COUNT,
  output logic                      BUSY
);

  localparam int XW    = $clog2(WIDTH) + 1;
  localparam int YW    = $clog2(HEIGHT) + 1;
  localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   fg_q, fg_d, bg_q, bg_d;
  logic [XW-1:0] x_d, bar_cnt_q, bar_cnt_d;
  logic [YW-1:0] y_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   data_d;
  logic          valid_d, fs_d, le_d, fe_d, busy_d;
  logic [7:0]    fc_d;
  logic          xfer, do_start, do_adv;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pattern(input logic [1:0] mode, input logic [15:0] fg,
                                          input logic [15:0] bg, input logic [XW-1:0] x,
                                          input logic [YW-1:0] y, input logic [2:0] bar,
                                          input logic [4:0] fc);
    logic [15:0] xe, ye, chk;
    xe  = 16'(x);
    ye  = 16'(y);
    chk = (xe >> CHECKER_LOG2) ^ (ye >> CHECKER_LOG2);
    case (mode)
      2'd0:    return fg;
      2'd1:    return bar_color(bar);
      2'd2:    return (|(chk & 16'd1)) ? fg : bg;
      default: return ((xe >> 3) << 11) | (((ye >> 1) & 16'h003F) << 5) | {11'd0, fc};
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    x_d       = PIXEL_X;
    y_d       = PIXEL_Y;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    gap_d     = gap_q;
    data_d    = PIXEL_DATA;
    valid_d   = PIXEL_VALID;
    fs_d      = FRAME_START;
    le_d      = LINE_END;
    fe_d      = FRAME_END;
    fc_d      = FRAME_COUNT;
    do_start  = 1'b0;
    do_adv    = 1'b0;
    xfer      = PIXEL_VALID && PIXEL_READY;

    unique case (state_q)
      S_IDLE: do_start = ENABLE;
      S_STREAM: begin
        if (xfer) begin
          if (FRAME_END) begin
            fc_d    = FRAME_COUNT + 8'd1;
            valid_d = 1'b0;
            fs_d    = 1'b0;
            le_d    = 1'b0;
            fe_d    = 1'b0;
            gap_d   = '0;
            // With no gap, IDLE makes the restart decision one clock later.
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          if (ENABLE) do_start = 1'b1;
          else        state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_start) begin
      mode_d    = MODE;
      fg_d      = FG_COLOR;
      bg_d      = BG_COLOR;
      x_d       = '0;
      y_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      state_d   = S_STREAM;
    end

    if (do_adv) begin
      if (PIXEL_X == X_LAST) begin
        x_d       = '0;
        y_d       = PIXEL_Y + 1'b1;
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else begin
        x_d = PIXEL_X + 1'b1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end

    if (do_start || do_adv) begin
      valid_d = 1'b1;
      data_d  = pattern(mode_d, fg_d, bg_d, x_d, y_d, bar_idx_d, FRAME_COUNT[4:0]);
`ifdef PIXSRC_BORDER_EN
      if (x_d == '0 || x_d == X_LAST || y_d == '0 || y_d == Y_LAST) data_d = fg_d;
`else
`endif
      fs_d = (x_d == '0) && (y_d == '0);
      le_d = (x_d == X_LAST);
      fe_d = le_d && (y_d == Y_LAST);
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      gap_q       <= '0;
      PIXEL_DATA  <= '0;
      PIXEL_VALID <= 1'b0;
      FRAME_START <= 1'b0;
      LINE_END    <= 1'b0;
      FRAME_END   <= 1'b0;
      PIXEL_X     <= '0;
      PIXEL_Y     <= '0;
      FRAME_COUNT <= '0;
      BUSY        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      gap_q       <= gap_d;
      PIXEL_DATA  <= data_d;
      PIXEL_VALID <= valid_d;
      FRAME_START <= fs_d;
      LINE_END    <= le_d;
      FRAME_END   <= fe_d;
      PIXEL_X     <= x_d;
      PIXEL_Y     <= y_d;
      FRAME_COUNT <= fc_d;
      BUSY        <= busy_d;
    end
  end

endmodule

// File: tb/tb_st7735_pixel_source.sv
// Scoreboard bench for st7735_pixel_source: two small instances (8x4 with gap, 20x3 without gap).
module tb_st7735_pixel_source;

  localparam int A_W = 8,  A_H = 4, A_CL = 1, A_GAP = 2;
  localparam int B_W = 20, B_H = 3, B_CL = 3, B_GAP = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        fs;
    logic        le;
    logic        fe;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, ready_a, valid_a, fs_a, le_a, fe_a, busy_a;
  logic [1:0]  mode_a;
  logic [15:0] fg_a, bg_a, data_a;
  logic [3:0]  x_a;
  logic [2:0]  y_a;
  logic [7:0]  fc_a;
  logic        en_b, ready_b, valid_b, fs_b, le_b, fe_b, busy_b;
  logic [1:0]  mode_b;
  logic [15:0] fg_b, bg_b, data_b;
  logic [5:0]  x_b;
  logic [2:0]  y_b;
  logic [7:0]  fc_b;

  st7735_pixel_source #(.WIDTH(A_W), .HEIGHT(A_H), .CHECKER_LOG2(A_CL), .GAP_CYCLES(A_GAP)) dut_a (
    .SYSTEM_CLK(clk), .RESET_N(rst_n), .ENABLE(en_a), .MODE(mode_a), .FG_COLOR(fg_a),
    .BG_COLOR(bg_a), .PIXEL_DATA(data_a), .PIXEL_VALID(valid_a), .PIXEL_READY(ready_a),
    .FRAME_START(fs_a), .LINE_END(le_a), .FRAME_END(fe_a), .PIXEL_X(x_a), .PIXEL_Y(y_a),
    .FRAME_COUNT(fc_a), .BUSY(busy_a));

  st7735_pixel_source #(.WIDTH(B_W), .HEIGHT(B_H), .CHECKER_LOG2(B_CL), .GAP_CYCLES(B_GAP)) dut_b (
    .SYSTEM_CLK(clk), .RESET_N(rst_n), .ENABLE(en_b), .MODE(mode_b), .FG_COLOR(fg_b),
    .BG_COLOR(bg_b), .PIXEL_DATA(data_b), .PIXEL_VALID(valid_b), .PIXEL_READY(ready_b),
    .FRAME_START(fs_b), .LINE_END(le_b), .FRAME_END(fe_b), .PIXEL_X(x_b), .PIXEL_Y(y_b),
    .FRAME_COUNT(fc_b), .BUSY(busy_b));

  int   n_vec = 0, n_err = 0;
  int   xfers_a = 0, xfers_b = 0;
  bit   bp_en = 1'b0;
  pix_t q_a[$], q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: condition not reached or unexpected event at %0t", name, $time);
  endtask

  function automatic logic [15:0] palette(input int idx);
    case (idx)
      0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;  3: return 16'h07E0;
      4: return 16'hF81F;  5: return 16'hF800;  6: return 16'h001F;  default: return 16'h0000;
    endcase
  endfunction

  // Reference pixel: bar index by division (saturated), checker by cell parity.
  function automatic pix_t model(input int w, input int h, input int cl, input int mode,
                                 input logic [15:0] fg, input logic [15:0] bg,
                                 input int x, input int y, input int fc);
    logic [15:0] d;
    int bw, idx;
    bw  = (w / 8 < 1) ? 1 : w / 8;
    idx = x / bw;
    if (idx > 7) idx = 7;
    case (mode)
      0:       d = fg;
      1:       d = palette(idx);
      2:       d = ((((x >> cl) ^ (y >> cl)) & 1) != 0) ? fg : bg;
      default: d = 16'((((x >> 3) & 31) << 11) | (((y >> 1) & 63) << 5) | (fc & 31));
    endcase
`ifdef PIXSRC_BORDER_EN
    if (x == 0 || x == w - 1 || y == 0 || y == h - 1) d = fg;
`endif
    return '{d, 8'(x), 8'(y), (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)};
  endfunction

  task automatic push_frame(input bit which, input int mode, input logic [15:0] fg,
                            input logic [15:0] bg, input int fc);
    if (!which) begin
      for (int y = 0; y < A_H; y++)
        for (int x = 0; x < A_W; x++) q_a.push_back(model(A_W, A_H, A_CL, mode, fg, bg, x, y, fc));
    end else begin
      for (int y = 0; y < B_H; y++)
        for (int x = 0; x < B_W; x++) q_b.push_back(model(B_W, B_H, B_CL, mode, fg, bg, x, y, fc));
    end
  endtask

  // Monitor A: pops on each transfer, and checks outputs stay put across each stall.
  pix_t act_a, snap_a, exp_a;
  bit   stalled_a = 1'b0;
  always @(negedge clk) begin
    act_a = '{data_a, 8'(x_a), 8'(y_a), fs_a, le_a, fe_a};
    if (stalled_a) begin
      check("stall_hold_a", 64'(act_a), 64'(snap_a));
      check("stall_valid_a", 64'(valid_a), 64'd1);
    end
    stalled_a = 1'b0;
    if (rst_n && valid_a) begin
      if (ready_a) begin
        xfers_a++;
        if (q_a.size() == 0) fail("extra_xfer_a");
        else begin
          exp_a = q_a.pop_front();
          check("pix_a", 64'(act_a), 64'(exp_a));
        end
      end else begin
        stalled_a = 1'b1;
        snap_a    = act_a;
      end
    end
  end

  pix_t act_b, exp_b;
  always @(negedge clk) begin
    act_b = '{data_b, 8'(x_b), 8'(y_b), fs_b, le_b, fe_b};
    if (rst_n && valid_b && ready_b) begin
      xfers_b++;
      if (q_b.size() == 0) fail("extra_xfer_b");
      else begin
        exp_b = q_b.pop_front();
        check("pix_b", 64'(act_b), 64'(exp_b));
      end
    end
  end

  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_a = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!which && q_a.size() == 0 && !busy_a && !valid_a) return;
      if (which && q_b.size() == 0 && !busy_b && !valid_b) return;
      tick();
    end
    fail(which ? "timeout_idle_b" : "timeout_idle_a");
  endtask

  task automatic wait_start(input bit which, input int fc, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!which && valid_a && fs_a && fc_a == 8'(fc)) return;
      if (which && valid_b && fs_b && fc_b == 8'(fc)) return;
      tick();
    end
    fail("timeout_frame_start");
  endtask

  task automatic wait_xfers_a(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (xfers_a >= n) return;
      tick();
    end
    fail("timeout_xfers_a");
  endtask

  task automatic wait_pix_a(input int x, input int y, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (valid_a && x_a == 4'(x) && y_a == 3'(y)) return;
      tick();
    end
    fail("timeout_pixel_a");
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; mode_a = 2'd0; fg_a = '0; bg_a = '0;
    en_b = 1'b0; mode_b = 2'd0; fg_b = '0; bg_b = '0;
    ready_b = 1'b1;
    repeat (3) tick();
    check("rst_valid_a", 64'(valid_a), 64'd0);
    check("rst_busy_a",  64'(busy_a),  64'd0);
    check("rst_fc_a",    64'(fc_a),    64'd0);
    check("rst_data_a",  64'(data_a),  64'd0);
    check("rst_xy_a",    64'({x_a, y_a}), 64'd0);
    check("rst_marks_a", 64'({fs_a, le_a, fe_a}), 64'd0);
    check("rst_valid_b", 64'(valid_b), 64'd0);
    check("rst_fc_b",    64'(fc_b),    64'd0);
    rst_n = 1'b1;
    tick();

    // Solid F800, one frame from a single ENABLE pulse.
    mode_a = 2'd0; fg_a = 16'hF800; bg_a = 16'h0000;
    push_frame(0, 0, 16'hF800, 16'h0000, 0);
    pulse_a();
    wait_idle(0, 200);
    check("solid_fc_a",    64'(fc_a),   64'd1);
    check("solid_busy_a",  64'(busy_a), 64'd0);
    check("solid_xfers_a", 64'(xfers_a), 64'd32);

    // Gradient under random backpressure; FRAME_COUNT=1 lands in the low 5 bits.
    mode_a = 2'd3;
    push_frame(0, 3, 16'h0000, 16'h0000, 1);
    bp_en = 1'b1;
    pulse_a();
    wait_idle(0, 2000);
    bp_en = 1'b0;
    tick();
    check("grad_fc_a", 64'(fc_a), 64'd2);

    // Checker frame; MODE/FG changed mid-frame only affect the following frame.
    mode_a = 2'd2; fg_a = 16'hFFFF; bg_a = 16'h0000;
    push_frame(0, 2, 16'hFFFF, 16'h0000, 2);
    push_frame(0, 0, 16'h07FF, 16'h0000, 3);
    en_a = 1'b1;
    wait_xfers_a(xfers_a + 5, 200);
    mode_a = 2'd0; fg_a = 16'h07FF;
    wait_start(0, 3, 200);
    en_a = 1'b0;
    wait_idle(0, 200);
    check("chk_fc_a", 64'(fc_a), 64'd4);

    // Reset during the 14th pixel aborts the frame with nothing left over.
    mode_a = 2'd0; fg_a = 16'h07E0;
    push_frame(0, 0, 16'h07E0, 16'h0000, 4);
    pulse_a();
    wait_pix_a(4, 1, 200);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_valid_a", 64'(valid_a), 64'd0);
    check("rst_mid_fc_a",    64'(fc_a),    64'd0);
    check("rst_mid_busy_a",  64'(busy_a),  64'd0);
    check("rst_mid_left_a",  64'(q_a.size()), 64'd19);
    q_a.delete();
    rst_n = 1'b1;
    tick();
    push_frame(0, 0, 16'h07E0, 16'h0000, 0);
    pulse_a();
    wait_idle(0, 200);
    check("restart_fc_a", 64'(fc_a), 64'd1);

    // Colour bars at WIDTH=8 (one pixel per bar).
    mode_a = 2'd1; fg_a = 16'h1234;
    push_frame(0, 1, 16'h1234, 16'h0000, 1);
    pulse_a();
    wait_idle(0, 200);
    check("bars_fc_a", 64'(fc_a), 64'd2);

    // WIDTH=20 bars, two back-to-back frames with no gap.
    mode_b = 2'd1; fg_b = 16'h1234; bg_b = 16'h0000;
    push_frame(1, 1, 16'h1234, 16'h0000, 0);
    push_frame(1, 1, 16'h1234, 16'h0000, 1);
    en_b = 1'b1;
    wait_start(1, 1, 300);
    en_b = 1'b0;
    wait_idle(1, 300);
    check("bars_fc_b",    64'(fc_b),    64'd2);
    check("bars_xfers_b", 64'(xfers_b), 64'd120);

    repeat (4) tick();
    check("final_q_a", 64'(q_a.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
